// File: rtl/user_wb_arbiter_if.sv
// Bus bundle for user_wb_arbiter: NM Wishbone masters plus one slave.
// Ports: m_* master-side request/response, s_* slave-side, grant_o owner.
interface user_wb_arbiter_if #(
  parameter int NM = 2
);
  logic [NM-1:0]    m_cyc_i;
  logic [NM-1:0]    m_stb_i;
  logic [NM-1:0]    m_we_i;
  logic [4*NM-1:0]  m_sel_i;
  logic [32*NM-1:0] m_adr_i;
  logic [32*NM-1:0] m_dat_i;
  logic [NM-1:0]    m_ack_o;
  logic [NM-1:0]    m_err_o;
  logic [31:0]      m_dat_o;
  logic             s_cyc_o;
  logic             s_stb_o;
  logic             s_we_o;
  logic [3:0]       s_sel_o;
  logic [31:0]      s_adr_o;
  logic [31:0]      s_dat_o;
  logic [31:0]      s_dat_i;
  logic             s_ack_i;
  logic [NM-1:0]    grant_o;

  modport arb (
    input  m_cyc_i, m_stb_i, m_we_i,
    input  m_sel_i, m_adr_i, m_dat_i,
    output m_ack_o, m_err_o, m_dat_o,
    output s_cyc_o, s_stb_o, s_we_o,
    output s_sel_o, s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i,
    output grant_o
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i,
    output m_sel_i, m_adr_i, m_dat_i,
    input  m_ack_o, m_err_o, m_dat_o,
    input  grant_o
  );

  modport slave (
    input  s_cyc_o, s_stb_o, s_we_o,
    input  s_sel_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i
  );
endinterface

// File: rtl/user_wb_arbiter.sv
// Round-robin CYC-locked Wishbone arbiter, NM masters onto one slave.
// Ports: wb_clk_i, wb_rst_i (sync, active high), bus (arb modport).
// Optional hung-transfer abort: define WB_ARB_TIMEOUT_EN.
module user_wb_arbiter #(
  parameter int NM      = 2,
  parameter int TIMEOUT = 255
) (
  input logic            wb_clk_i,
  input logic            wb_rst_i,
  user_wb_arbiter_if.arb bus
);
  localparam int PW = $clog2(NM);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t        state;
  logic [NM-1:0] grant;
  logic [PW-1:0] ptr;
  logic [PW-1:0] own;
  logic [PW-1:0] pick;
  logic [PW-1:0] nxt;
  logic [NM-1:0] rot;
  logic          found;
  logic          act;
  logic          tmo;
  logic          o_cyc;
  logic          o_stb;

  assign act   = (state == OWNED);
  assign o_cyc = bus.m_cyc_i[own];
  assign o_stb = bus.m_stb_i[own];
  assign nxt   = (32'(own) == NM - 1) ? '0 : own + 1'b1;

`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] cnt;
  assign tmo = act && (cnt == 8'(TIMEOUT));
`else
  assign tmo = 1'b0;
`endif

  // Rotate requests so bit 0 is the master at ptr; lowest set bit wins.
  always_comb begin
    rot   = NM'({bus.m_cyc_i, bus.m_cyc_i} >> ptr);
    pick  = ptr;
    found = 1'b0;
    for (int i = NM - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pick  = PW'((int'(ptr) + i) % NM);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
      own   <= '0;
`ifdef WB_ARB_TIMEOUT_EN
      cnt   <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            state <= OWNED;
            own   <= pick;
            grant <= NM'(1) << pick;
          end
        end
        OWNED: begin
          if (!o_cyc || tmo) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= nxt;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef WB_ARB_TIMEOUT_EN
      // Counts consecutive strobed-but-unacked cycles of the owner.
      if (!act || tmo || !o_cyc)
        cnt <= '0;
      else if (o_stb && !bus.s_ack_i)
        cnt <= cnt + 8'd1;
      else
        cnt <= '0;
`endif
    end
  end

  // Owner's request passes straight through; timeout masks CYC/STB.
  always_comb begin
    bus.s_cyc_o = 1'b0;
    bus.s_stb_o = 1'b0;
    bus.s_we_o  = 1'b0;
    bus.s_sel_o = '0;
    bus.s_adr_o = '0;
    bus.s_dat_o = '0;
    bus.m_ack_o = '0;
    bus.m_err_o = '0;
    if (act) begin
      bus.s_cyc_o      = o_cyc & ~tmo;
      bus.s_stb_o      = o_cyc & o_stb & ~tmo;
      bus.s_we_o       = bus.m_we_i[own];
      bus.s_sel_o      = bus.m_sel_i[{own, 2'b00} +: 4];
      bus.s_adr_o      = bus.m_adr_i[{own, 5'b00000} +: 32];
      bus.s_dat_o      = bus.m_dat_i[{own, 5'b00000} +: 32];
      bus.m_ack_o[own] = bus.s_ack_i & ~tmo;
      bus.m_err_o[own] = tmo;
    end
  end

  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.grant_o = grant;
endmodule
